// File: rtl/booth_mult_sched.sv
// Radix-2 Booth multiplier shared by two requesters through an arbiter.
// Define BOOTH_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module booth_mult_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_z,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_1;
  logic             id;
  logic [CW-1:0]    cnt;

  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

`ifdef BOOTH_SCHED_FIXED_PRIO_EN
  assign grant = ~req_valid[0];
`else
  logic ptr;

  // Contention goes to the pointer side; a lone requester always wins.
  always_comb begin
    if (req_valid == 2'b11) grant = ptr;
    else                    grant = ~req_valid[0];
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (xfer) ptr <= ~grant;
  end
`endif

  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE && !rst && |req_valid)
      req_ready = grant ? 2'b10 : 2'b01;
  end

  assign xfer  = |(req_valid & req_ready);
  assign sel_x = grant ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
  assign sel_y = grant ? req_y[2*WIDTH-1:WIDTH] : req_y[WIDTH-1:0];

  // A carries one guard bit so -2^(WIDTH-1) as M cannot overflow.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    unique case (1'b1)
      q[0] & ~q_1: sum = a - m_ext;
      ~q[0] & q_1: sum = a + m_ext;
      default:     sum = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      id    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            m     <= sel_y;
            q     <= sel_x;
            id    <= grant;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          a     <= '0;
          q_1   <= 1'b0;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          a   <= {sum[WIDTH], sum[WIDTH:1]};
          q   <= {sum[0], q[WIDTH-1:1]};
          q_1 <= q[0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign res_id    = id;
  assign res_z     = {a[WIDTH-1:0], q};

endmodule
